// File: rtl/sipo_frame_buffer_if.sv
// Sample-in / frame-out handshake bundle for sipo_frame_buffer.
// The master drives samples and frame acceptance; the slave is the buffer itself.
interface sipo_frame_buffer_if #(
  parameter int DATA_W = 16,
  parameter int N      = 32,
  parameter int CNT_W  = $clog2(N) + 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] d_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [N*DATA_W-1:0]      d_out;
  logic                     frame_done;
  logic [CNT_W-1:0]         count;
  logic                     overrun;

  modport master (
    output in_valid, d_in, out_ready,
    input  in_ready, out_valid, d_out, frame_done, count, overrun
  );

  modport slave (
    input  in_valid, d_in, out_ready,
    output in_ready, out_valid, d_out, frame_done, count, overrun
  );
endinterface

// File: rtl/sipo_frame_buffer.sv
// Serial-in/parallel-out frame buffer with hop framing; a frame is valid the cycle after its last sample.
// in_ready drops while a finished frame waits unconsumed; samples offered then set the sticky overrun flag.
module sipo_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int N      = 32,
  parameter int HOP    = 32,
  parameter int CNT_W  = $clog2(N) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  sipo_frame_buffer_if.slave bus
);
  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] HOP_LAST   = CNT_W'(HOP - 1);

  logic [N*DATA_W-1:0] frame_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                primed_q;
  logic                out_vld_q;
  logic                done_q;
  logic                ovr_q;
  logic                in_rdy;
  logic                accept;
  logic                complete;

  // A frame handshake frees the buffer in the same cycle, so a sample may shift in alongside it.
  assign in_rdy   = !out_vld_q || bus.out_ready;
  assign accept   = bus.in_valid && in_rdy;
  assign complete = accept && (cnt_q == (primed_q ? HOP_LAST : FIRST_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (flush) begin
      frame_q   <= '0;
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_vld_q <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (accept) begin
        // Newest sample enters the top word while word 0 (oldest) falls off.
        frame_q <= {bus.d_in, frame_q[N*DATA_W-1:DATA_W]};
        cnt_q   <= complete ? '0 : cnt_q + CNT_W'(1);
      end
      if (complete) begin
        primed_q <= 1'b1;
      end
      if (complete) begin
        out_vld_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_vld_q <= 1'b0;
      end
      done_q <= complete;
      if (bus.in_valid && !in_rdy) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld_q;
  assign bus.d_out      = frame_q;
  assign bus.frame_done = done_q;
  assign bus.count      = cnt_q;
  assign bus.overrun    = ovr_q;
endmodule
